// File: rtl/shift_exec_stage.sv
// ---------------------------------------------------------------------------
// shift_exec_stage
//
// Two-stage pipelined execute slot for shift instructions (SLL/SRL/SRA/ROR).
// S1 latches the decoded op, rs1, the resolved 5-bit shift amount and the
// destination tag. The shift is computed combinationally from S1. S2
// registers the result, the tag and the zero/neg flags for writeback. Both
// the upstream and the downstream side use a valid/ready handshake. The
// stage sustains one op per cycle and honours downstream backpressure.
//
// Parameters:
//   WIDTH    datapath width (fixed at 32)
//   SHAMT_W  shift-amount width (log2 WIDTH)
//   TAG_W    destination-register tag width
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      upstream offers an operation
//   in_ready      stage can accept this cycle
//   in_op         00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_amt_sel    0: amount = in_rs2[4:0], 1: amount = in_shamt
//   in_rs1        value to shift
//   in_rs2        register amount source (only low SHAMT_W bits used)
//   in_shamt      immediate amount
//   in_tag        destination register index
//   out_valid     result available
//   out_ready     downstream accepts result
//   out_data      shifted result
//   out_tag       tag of result
//   out_zero      out_data == 0
//   out_neg       out_data MSB
// ---------------------------------------------------------------------------
module shift_exec_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic               in_amt_sel,
    input  logic [WIDTH-1:0]   in_rs1,
    input  logic [WIDTH-1:0]   in_rs2,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero,
    output logic               out_neg
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // S1: operand register
    logic               s1_valid;
    logic [1:0]         s1_op;
    logic [WIDTH-1:0]   s1_rs1;
    logic [SHAMT_W-1:0] s1_amt;
    logic [TAG_W-1:0]   s1_tag;

    // S2: result register
    logic               s2_valid;
    logic [WIDTH-1:0]   s2_data;
    logic [TAG_W-1:0]   s2_tag;
    logic               s2_zero;
    logic               s2_neg;

    logic               s1_load;
    logic               s2_load;
    logic               out_fire;
    logic [SHAMT_W-1:0] in_amt;

    logic [WIDTH-1:0]   shift_res;
    logic [2*WIDTH-1:0] ror_wide;
    logic signed [WIDTH-1:0] rs1_signed;

    // Only the low amount bits of rs2 are architecturally meaningful;
    // the upper bits are deliberately ignored.
    logic unused_rs2_bits;
    assign unused_rs2_bits = &{1'b0, in_rs2[WIDTH-1:SHAMT_W]};

    // S2 can take a new entry when it is empty or draining this cycle.
    // in_ready reuses that so a full S1 still accepts when it moves on,
    // which is what gives full throughput and collapses bubbles.
    assign out_fire = s2_valid && out_ready;
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    assign in_amt = in_amt_sel ? in_shamt : in_rs2[SHAMT_W-1:0];

    // Rotate is taken from the low half of rs1 doubled and shifted right,
    // which makes an amount of 0 pass rs1 unchanged with no special case.
    assign ror_wide   = {s1_rs1, s1_rs1} >> s1_amt;
    assign rs1_signed = s1_rs1;

    always_comb begin
        shift_res = '0;
        case (s1_op)
            OP_SLL:  shift_res = s1_rs1 << s1_amt;
            OP_SRL:  shift_res = s1_rs1 >> s1_amt;
            OP_SRA:  shift_res = rs1_signed >>> s1_amt;
            OP_ROR:  shift_res = ror_wide[WIDTH-1:0];
            default: shift_res = '0;
        endcase
    end

    // Operand stage. Data is only written on a capture, so it holds
    // stable while S1 waits behind a stalled S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_rs1   <= '0;
            s1_amt   <= '0;
            s1_tag   <= '0;
        end else begin
            s1_valid <= s1_load || (s1_valid && !s2_load);
            if (s1_load) begin
                s1_op  <= in_op;
                s1_rs1 <= in_rs1;
                s1_amt <= in_amt;
                s1_tag <= in_tag;
            end
        end
    end

    // Result stage. Flags are derived from the shift result before it is
    // registered so the outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
            s2_zero  <= 1'b0;
            s2_neg   <= 1'b0;
        end else begin
            s2_valid <= s2_load || (s2_valid && !out_fire);
            if (s2_load) begin
                s2_data <= shift_res;
                s2_tag  <= s1_tag;
                s2_zero <= (shift_res == '0);
                s2_neg  <= shift_res[WIDTH-1];
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_tag   = s2_tag;
    assign out_zero  = s2_zero;
    assign out_neg   = s2_neg;

endmodule

// File: tb/tb_shift_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_exec_stage
//
// Self-checking bench for shift_exec_stage. Every accepted operation is
// pushed onto a scoreboard with its result computed arithmetically from the
// shift rules. Every result that leaves the stage is checked in order
// against that scoreboard. Directed steps cover reset, latency, the edge
// amounts, back-to-back streaming, stalls and reset mid-flight. A randomized
// phase follows.
// ---------------------------------------------------------------------------
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic        in_amt_sel = 1'b0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_shamt = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_zero;
    logic        out_neg;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } result_t;

    result_t sb[$];

    int vectors     = 0;
    int miscompares = 0;
    int out_count   = 0;

    // Snapshot of the most recent cycle, taken mid-cycle
    logic        last_out_fire;
    logic        last_in_ready;
    logic        last_out_valid;
    logic [31:0] last_out_data;
    logic [4:0]  last_out_tag;

    shift_exec_stage #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_amt_sel (in_amt_sel),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

    always #5 clk = ~clk;

    // Reference shift computed with plain integer arithmetic
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input int a);
        longint unsigned w;
        longint unsigned p;
        w = x;
        p = 64'd1 << a;
        case (op)
            2'd0: return 32'((w * p) % 64'h1_0000_0000);
            2'd1: return 32'(w / p);
            2'd2: begin
                if (x[31]) return ~32'((~w & 64'hFFFF_FFFF) / p);
                else       return 32'(w / p);
            end
            default: return 32'((w / p) + ((w % p) * (64'd1 << (32 - a))));
        endcase
    endfunction

    task automatic compare(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Checks whatever leaves the stage this cycle against the scoreboard
    task automatic checkOutput();
        result_t e;
        last_out_fire  = out_valid && out_ready;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        last_out_data  = out_data;
        last_out_tag   = out_tag;
        if (out_valid && out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
                compare("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                compare("out_data", out_data, e.data);
                compare("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
                compare("out_zero", {31'd0, out_zero}, {31'd0, (e.data == 32'd0)});
                compare("out_neg", {31'd0, out_neg}, {31'd0, e.data[31]});
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, observe, then let the
    // rising edge perform the transfers.
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic sel,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [4:0] shamt, input logic [4:0] tag,
                                 input logic ordy);
        result_t e;
        int a;
        @(negedge clk);
        in_valid   = v;
        in_op      = op;
        in_amt_sel = sel;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_shamt   = shamt;
        in_tag     = tag;
        out_ready  = ordy;
        #1;
        checkOutput();
        if (in_valid && in_ready && !rst) begin
            a = sel ? int'(shamt) : int'(rs2 % 32);
            e.data = model(op, rs1, a);
            e.tag  = tag;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
        compare("drain_left", sb.size(), 32'd0);
    endtask

    initial begin
        int base;
        $display("[TB] start");

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        compare("rst_out_valid", {31'd0, out_valid}, 32'd0);
        compare("rst_out_data", out_data, 32'd0);
        compare("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        idle(1'b1);
        compare("idle_out_valid", {31'd0, last_out_valid}, 32'd0);

        // SRA with immediate amount, checking two-cycle latency
        applyStimulus(1'b1, 2'd2, 1'b1, 32'h8000_0000, 32'd0, 5'd4, 5'd7, 1'b1);
        idle(1'b1);
        compare("lat_edge1_valid", {31'd0, last_out_valid}, 32'd0);
        idle(1'b1);
        compare("lat_edge2_valid", {31'd0, last_out_valid}, 32'd1);
        compare("sra_data", last_out_data, 32'hF800_0000);
        compare("sra_tag", {27'd0, last_out_tag}, 32'd7);

        // Edge amounts, issued back to back
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h8000_0000, 32'h0000_0024, 5'd0, 5'd1, 1'b1);
        applyStimulus(1'b1, 2'd0, 1'b1, 32'h0000_0001, 32'd0, 5'd31, 5'd2, 1'b1);
        applyStimulus(1'b1, 2'd3, 1'b1, 32'h0000_000F, 32'd0, 5'd4, 5'd3, 1'b1);
        applyStimulus(1'b1, 2'd1, 1'b1, 32'h0000_00FF, 32'd0, 5'd8, 5'd4, 1'b1);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h8765_4321, 32'd33, 5'd0, 5'd5, 1'b1);
        for (int op = 0; op < 4; op++)
            applyStimulus(1'b1, 2'(op), 1'b0, 32'h1234_5678, 32'd32, 5'd9, 5'(8 + op), 1'b1);
        drain();

        // Back-to-back stream: one result per cycle once the pipe is full
        base = out_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom, 5'($urandom_range(0, 31)), 5'(i), 1'b1);
            compare("stream_fire", {31'd0, last_out_fire}, (i >= 2) ? 32'd1 : 32'd0);
        end
        idle(1'b1);
        idle(1'b1);
        compare("stream_count", out_count - base, 32'd8);

        // Stall with both stages full, then release
        base = out_count;
        applyStimulus(1'b1, 2'd3, 1'b1, 32'hA5A5_0F0F, 32'd0, 5'd12, 5'd20, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b1, 32'hC000_0001, 32'd0, 5'd3, 5'd21, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF, 32'd0, 5'd1, 5'd22, 1'b0);
            compare("stall_in_ready", {31'd0, last_in_ready}, 32'd0);
            compare("stall_out_valid", {31'd0, last_out_valid}, 32'd1);
            compare("stall_out_data", last_out_data, sb[0].data);
            compare("stall_out_tag", {27'd0, last_out_tag}, {27'd0, sb[0].tag});
        end
        drain();
        compare("stall_count", out_count - base, 32'd2);

        // Reset with two ops in flight
        applyStimulus(1'b1, 2'd0, 1'b1, 32'h0000_0003, 32'd0, 5'd2, 5'd30, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b1, 32'hFFFF_0000, 32'd0, 5'd4, 5'd31, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        compare("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        compare("midrst_out_data", out_data, 32'd0);
        compare("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        idle(1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            compare("post_rst_valid", {31'd0, last_out_valid}, 32'd0);
        end

        // Randomized traffic with random backpressure
        for (int i = 0; i < 200; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom, $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 3) != 0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
